// File: rtl/mux_n_to_1_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_to_1_rr
// Description : N-to-1 registered channel multiplexer with a one-word output
//               buffer. Each capture picks one channel, either the channel
//               named by sel (direct mode) or by rotating-priority
//               round-robin arbitration (arbitration mode).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_to_1_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // The channel count is widened by one bit so that range checks and the
    // wrap-around of the scan index never overflow the select width.
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N-1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [WIDTH-1:0]   ch_data [N];
    logic               load_en;
    logic               cand_found;
    logic [SEL_W-1:0]   cand_idx;
    logic [SEL_W:0]     scan_idx;
    logic               capture;

    // Split the packed input bus into one word per channel.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign ch_data[gi] = in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Candidate selection: direct index or first valid channel from ptr.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        if (!mode) begin
            if ({1'b0, sel} < N_EXT) begin
                cand_idx   = sel;
                cand_found = in_valid[sel];
            end
        end else begin
            // Scan from the farthest position back toward ptr so that the
            // last hit written is the one nearest to ptr in rotation order.
            for (int k = N-1; k >= 0; k--) begin
                scan_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (scan_idx >= N_EXT) begin
                    scan_idx = scan_idx - N_EXT;
                end
                if (in_valid[scan_idx[SEL_W-1:0]]) begin
                    cand_found = 1'b1;
                    cand_idx   = scan_idx[SEL_W-1:0];
                end
            end
        end
    end

    // Capture decision and per-channel accept strobe; no accepts in reset.
    always_comb begin
        load_en  = (state_q == EMPTY) || out_ready;
        capture  = load_en && cand_found && reset_n;
        in_ready = capture ? (N'(1) << cand_idx) : '0;
    end

    // Next-state: capture refills the buffer, a consumed word empties it.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_sel_d = out_sel_q;
        ptr_d     = ptr_q;
        if (capture) begin
            state_d   = FULL;
            out_d     = ch_data[cand_idx];
            out_sel_d = cand_idx;
            if (mode) begin
                ptr_d = (cand_idx == IDX_LAST) ? '0 : cand_idx + IDX_ONE;
            end
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State and output buffer registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            out_sel_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_sel_q <= out_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = (state_q == FULL);

endmodule
`default_nettype wire

// File: tb/tb_mux_n_to_1_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_to_1_rr
// Description : Directed self-checking bench for mux_n_to_1_rr (N=4, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_to_1_rr;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                clock;
    logic                reset_n;
    logic [N*WIDTH-1:0]  data_in;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [WIDTH-1:0]    data_out;
    logic [SEL_W-1:0]    out_sel;
    logic                out_valid;
    logic                out_ready;

    int n_checks = 0;
    int n_errors = 0;

    mux_n_to_1_rr #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out       (data_out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] rr_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_sel   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] sk_ready [3] = '{4'b0001, 4'b0100, 4'b0001};
    logic [1:0] sk_sel   [3] = '{2'd0, 2'd2, 2'd0};

    initial begin
        reset_n   = 1'b0;
        data_in   = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'hF;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;

        // Reset state; accepts must stay low while reset is held.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out", 32'(data_out), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        check("rst_in_ready_clk", 32'(in_ready), 32'h0);

        // Direct mode, sel 0..3, back-to-back.
        mode    = 1'b0;
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("dir_in_ready", 32'(in_ready), 32'(4'b0001 << s));
            step();
            check("dir_out", 32'(data_out), 32'(exp_data[s]));
            check("dir_out_sel", 32'(out_sel), s);
            check("dir_out_valid", 32'(out_valid), 32'h1);
        end

        // Round-robin fairness; ptr must still be 0 after direct captures.
        mode = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("rr_in_ready", 32'(in_ready), 32'(rr_ready[s]));
            step();
            check("rr_out_sel", 32'(out_sel), 32'(rr_sel[s]));
            check("rr_out", 32'(data_out), 32'(exp_data[rr_sel[s]]));
            check("rr_out_valid", 32'(out_valid), 32'h1);
        end

        // Bring ptr to 3 by granting ch2, then skip and wrap with 0101.
        in_valid = 4'b0100;
        #1;
        check("sk_pre_ready", 32'(in_ready), 32'h4);
        step();
        in_valid = 4'b0101;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("sk_in_ready", 32'(in_ready), 32'(sk_ready[s]));
            step();
            check("sk_out_sel", 32'(out_sel), 32'(sk_sel[s]));
        end

        // Backpressure: hold 8'h22 for three cycles, then refill with ch2.
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'hF;
        step();
        check("bp_load_out", 32'(data_out), 32'h22);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            step();
            check("bp_out", 32'(data_out), 32'h22);
            check("bp_out_sel", 32'(out_sel), 32'h1);
            check("bp_out_valid", 32'(out_valid), 32'h1);
        end
        sel       = 2'd2;
        out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", 32'(in_ready), 32'h4);
        step();
        check("bp_rel_out", 32'(data_out), 32'h33);
        check("bp_rel_out_sel", 32'(out_sel), 32'h2);
        check("bp_rel_out_valid", 32'(out_valid), 32'h1);

        // Idle: selected channel not valid, pending word drains.
        in_valid = 4'b1011;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'h0);
        step();
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_out_hold", 32'(data_out), 32'h33);
        check("idle_out_sel_hold", 32'(out_sel), 32'h2);
        step();
        check("idle_stay_empty", 32'(out_valid), 32'h0);

        // Async reset while FULL with ptr moved to 2.
        mode     = 1'b1;
        in_valid = 4'b0010;
        step();
        check("ar_pre_out_sel", 32'(out_sel), 32'h1);
        check("ar_pre_out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'h0);
        check("ar_out", 32'(data_out), 32'h0);
        check("ar_out_sel", 32'(out_sel), 32'h0);
        check("ar_in_ready", 32'(in_ready), 32'h0);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("ar_first_ready", 32'(in_ready), 32'h1);
        step();
        check("ar_first_sel", 32'(out_sel), 32'h0);
        check("ar_first_out", 32'(data_out), 32'h11);
        check("ar_first_valid", 32'(out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
